// File: rtl/word_subtract_sequencer.sv
// Multi-byte subtract controller. Walks two NUM_BYTES-wide operands through an
// external byte_subtractor one byte per step (LSB first), chaining the borrow
// between steps, and presents the assembled difference on a start/done handshake.
module word_subtract_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BYTES  = 4,
  parameter int IDX_WIDTH  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_BYTES*DATA_WIDTH-1:0] operand_a,
  input  logic [NUM_BYTES*DATA_WIDTH-1:0] operand_b,
  input  logic                            borrow_in,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_BYTES*DATA_WIDTH-1:0] result,
  output logic                            borrow_out,
  output logic                            zero,
  output logic [DATA_WIDTH-1:0]           sub_a,
  output logic [DATA_WIDTH-1:0]           sub_b,
  output logic                            sub_borrow_in,
  output logic                            sub_start,
  input  logic [DATA_WIDTH-1:0]           sub_diff,
  input  logic                            sub_borrow_out,
  input  logic                            sub_done
);

  localparam int W = NUM_BYTES * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           a_q, a_d;
  logic [W-1:0]           b_q, b_d;
  logic [W-1:0]           acc_q, acc_d;
  logic                   brw_q, brw_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [W-1:0]           result_q, result_d;
  logic                   borrow_out_q, borrow_out_d;
  logic                   zero_q, zero_d;
  logic [W-1:0]           acc_upd_s;
  logic                   last_byte_s;

  // Next-state and datapath update; the accumulator with the current byte
  // merged in is what gets published on the final step.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    brw_d        = brw_q;
    idx_d        = idx_q;
    result_d     = result_q;
    borrow_out_d = borrow_out_q;
    zero_d       = zero_q;
    acc_upd_s    = acc_q;
    acc_upd_s[idx_q*DATA_WIDTH +: DATA_WIDTH] = sub_diff;
    last_byte_s  = (idx_q == IDX_WIDTH'(NUM_BYTES - 1));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = operand_a;
          b_d     = operand_b;
          brw_d   = borrow_in;
          idx_d   = {IDX_WIDTH{1'b0}};
          acc_d   = {W{1'b0}};
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (sub_done) begin
          acc_d = acc_upd_s;
          brw_d = sub_borrow_out;
          if (last_byte_s) begin
            state_d      = ST_DONE;
            result_d     = acc_upd_s;
            borrow_out_d = sub_borrow_out;
            zero_d       = (acc_upd_s == {W{1'b0}});
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      a_q          <= {W{1'b0}};
      b_q          <= {W{1'b0}};
      acc_q        <= {W{1'b0}};
      brw_q        <= 1'b0;
      idx_q        <= {IDX_WIDTH{1'b0}};
      result_q     <= {W{1'b0}};
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      brw_q        <= brw_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      borrow_out_q <= borrow_out_d;
      zero_q       <= zero_d;
    end
  end

  // Byte-subtractor drive decoded from registers; quiet (all zero) outside EXEC.
  always_comb begin
    sub_start     = 1'b0;
    sub_a         = {DATA_WIDTH{1'b0}};
    sub_b         = {DATA_WIDTH{1'b0}};
    sub_borrow_in = 1'b0;
    if (state_q == ST_EXEC) begin
      sub_start     = 1'b1;
      sub_a         = a_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
      sub_b         = b_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
      sub_borrow_in = brw_q;
    end else begin
      sub_start     = 1'b0;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign result     = result_q;
  assign borrow_out = borrow_out_q;
  assign zero       = zero_q;

endmodule
